// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM burst controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_ACC  = 3'd2,
    RD_ACC  = 3'd3,
    GAP     = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Beat width in bits for a given word size and words per beat.
  function automatic int beat_width(input int word_bytes, input int data_words);
    return 8 * word_bytes * data_words;
  endfunction

  // Counter width able to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Wrapping counter: counts 0..rollover_val_i while enabled, flags the final count.
// Latency: rollover_flag_o is combinational on the current count.
// Backpressure: none; clear_i has priority over counting.
// Ports: clk/n_rst clock and async active-low reset; clear_i forces zero;
//        count_en_i advances; rollover_val_i terminal count; rollover_flag_o
//        high in the enabled cycle where the count equals the terminal value.
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear_i,
  input  logic             count_en_i,
  input  logic [WIDTH-1:0] rollover_val_i,
  output logic             rollover_flag_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i) begin
      count_d = (count_q == rollover_val_i) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign rollover_flag_o = count_en_i && (count_q == rollover_val_i);

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst controller: one request -> req_len strided single-beat SRAM accesses.
// Latency: first enable the cycle after accept; read beat WAIT_CYCLES+2, write beat WAIT_CYCLES+3.
// Backpressure: req_ready only in IDLE; writes stall in WR_DATA on wdata_valid; no rdata backpressure.
// Ports: req_* request channel; wdata_* per-beat write data; rdata/rdata_valid read
//        strobe; done/err completion; busy; sram_* registered SRAM side.
// Optional: SRAM_CTRL_BOUND_CHECK_EN rejects bursts running past the top of
//           the address space (done=err=1, no access); otherwise addresses wrap.
module sram_burst_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_BITS   = 16,
  parameter int WORD_BYTES  = 1,
  parameter int DATA_WORDS  = 16,
  parameter int WAIT_CYCLES = 1,
  parameter int LEN_BITS    = 8,
  localparam int DW = beat_width(WORD_BYTES, DATA_WORDS)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [LEN_BITS-1:0]  req_len,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [DW-1:0]        wdata,
  output logic                 rdata_valid,
  output logic [DW-1:0]        rdata,
  output logic                 done,
  output logic                 err,
  output logic                 busy,
  output logic                 sram_read_enable,
  output logic                 sram_write_enable,
  output logic [ADDR_BITS-1:0] sram_address,
  output logic [DW-1:0]        sram_write_data,
  input  logic [DW-1:0]        sram_read_data
);

  localparam int                   CNT_W     = cnt_width(WAIT_CYCLES);
  localparam logic [ADDR_BITS-1:0] STRIDE    = ADDR_BITS'(DATA_WORDS);
  localparam logic [CNT_W-1:0]     WAIT_LAST = CNT_W'(WAIT_CYCLES);

  state_t                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [LEN_BITS-1:0]   beats_q, beats_d;
  logic [DW-1:0]         wdat_q, wdat_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic                  rvld_q, rvld_d;
  logic                  ren_q, ren_d;
  logic                  wen_q, wen_d;
  logic                  acc_en;
  logic                  acc_last;

`ifdef SRAM_CTRL_BOUND_CHECK_EN
  // Wide enough that addr + len*DATA_WORDS cannot overflow.
  localparam int EXT_W = ADDR_BITS + LEN_BITS + $clog2(DATA_WORDS + 1) + 1;
  logic [EXT_W-1:0] req_end;
  logic             bound_fail;
  logic             err_q, err_d;

  assign req_end    = EXT_W'(req_addr) + EXT_W'(req_len) * EXT_W'(DATA_WORDS);
  assign bound_fail = req_end > (EXT_W'(1) << ADDR_BITS);
`endif

  // Wait-state counter: runs only while an enable is held, so each access
  // starts from zero and its terminal count marks the last enable cycle.
  flex_counter #(
    .WIDTH(CNT_W)
  ) u_wait_cnt (
    .clk            (clk),
    .n_rst          (n_rst),
    .clear_i        (~acc_en),
    .count_en_i     (acc_en),
    .rollover_val_i (WAIT_LAST),
    .rollover_flag_o(acc_last)
  );

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    rvld_d  = 1'b0;
    acc_en  = 1'b0;
`ifdef SRAM_CTRL_BOUND_CHECK_EN
    err_d   = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          beats_d = req_len;
`ifdef SRAM_CTRL_BOUND_CHECK_EN
          err_d   = 1'b0;
`endif
          if (req_len == '0) begin
            state_d = DONE;
`ifdef SRAM_CTRL_BOUND_CHECK_EN
          end else if (bound_fail) begin
            err_d   = 1'b1;
            state_d = DONE;
`endif
          end else begin
            state_d = req_write ? WR_DATA : RD_ACC;
          end
        end
      end

      WR_DATA: begin
        if (wdata_valid) begin
          wdat_d  = wdata;
          state_d = WR_ACC;
        end
      end

      WR_ACC, RD_ACC: begin
        acc_en = 1'b1;
        if (acc_last) begin
          if (state_q == RD_ACC) begin
            rdata_d = sram_read_data;
            rvld_d  = 1'b1;
          end
          beats_d = beats_q - 1'b1;
          if (beats_q == LEN_BITS'(1)) begin
            state_d = DONE;
          end else begin
            // Address steps during the gap so it is settled before the next enable.
            addr_d  = addr_q + STRIDE;
            state_d = GAP;
          end
        end
      end

      GAP:     state_d = wr_q ? WR_DATA : RD_ACC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Enables are registered copies of the access states, so they switch on
    // the same edge the FSM enters or leaves an access.
    ren_d = (state_d == RD_ACC);
    wen_d = (state_d == WR_ACC);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      beats_q <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
`ifdef SRAM_CTRL_BOUND_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
`ifdef SRAM_CTRL_BOUND_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign req_ready         = (state_q == IDLE);
  assign busy              = (state_q != IDLE);
  assign wdata_ready       = (state_q == WR_DATA);
  assign done              = (state_q == DONE);
  assign rdata_valid       = rvld_q;
  assign rdata             = rdata_q;
  assign sram_read_enable  = ren_q;
  assign sram_write_enable = wen_q;
  assign sram_address      = addr_q;
  assign sram_write_data   = wdat_q;

`ifdef SRAM_CTRL_BOUND_CHECK_EN
  assign err = done && err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl with default geometry and WAIT_CYCLES=1.
// Drives bursts from a vector table, models the SRAM, and scoreboards accesses.
// Reports one summary line.
module tb_sram_burst_ctrl;

  localparam int W  = 1;
  localparam int DW = 128;

  logic           clk = 1'b0;
  logic           n_rst;
  logic           req_valid, req_ready, req_write;
  logic [15:0]    req_addr;
  logic [7:0]     req_len;
  logic           wdata_valid, wdata_ready;
  logic [DW-1:0]  wdata, rdata, sram_write_data, sram_read_data;
  logic           rdata_valid, done, err, busy;
  logic           sram_read_enable, sram_write_enable;
  logic [15:0]    sram_address;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_burst_ctrl #(
    .ADDR_BITS(16), .WORD_BYTES(1), .DATA_WORDS(16), .WAIT_CYCLES(W), .LEN_BITS(8)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata),
    .done(done), .err(err), .busy(busy),
    .sram_read_enable(sram_read_enable), .sram_write_enable(sram_write_enable),
    .sram_address(sram_address), .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int v);
    logic [15:0] t;
    t = v[15:0];
    return {8{t}};
  endfunction

  // SRAM model
  logic [DW-1:0] mem [logic [15:0]];
  always @(posedge clk) if (n_rst && sram_write_enable) mem[sram_address] = sram_write_data;
  always @(negedge clk)
    sram_read_data = (sram_read_enable && mem.exists(sram_address)) ? mem[sram_address] : '0;

  // Scoreboard queues
  logic [15:0]   wa_q[$];
  logic [15:0]   ra_q[$];
  logic [DW-1:0] wd_q[$];
  logic [DW-1:0] rd_q[$];

  int   done_cnt = 0;
  int   wen_run = 0, ren_run = 0;
  logic wen_prev = 1'b0, ren_prev = 1'b0;

  always @(negedge clk) begin
    if (sram_read_enable && sram_write_enable) check("en_exclusive", 1, 0);
    if (err && !done) check("err_without_done", 1, 0);
    if (sram_write_enable && !wen_prev) begin
      if (wa_q.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        check("wr_addr", sram_address, wa_q.pop_front());
        check("wr_data", sram_write_data, wd_q.pop_front());
      end
    end
    if (sram_write_enable) wen_run++;
    else if (wen_prev) begin
      check("wr_en_len", wen_run, W + 1);
      wen_run = 0;
    end
    if (sram_read_enable && !ren_prev) begin
      if (ra_q.size() == 0) check("rd_unexpected", 1, 0);
      else check("rd_addr", sram_address, ra_q.pop_front());
    end
    if (sram_read_enable) ren_run++;
    else if (ren_prev) begin
      check("rd_en_len", ren_run, W + 1);
      ren_run = 0;
    end
    if (rdata_valid) begin
      if (rd_q.size() == 0) check("rdata_unexpected", 1, 0);
      else check("rdata", rdata, rd_q.pop_front());
    end
    if (done) done_cnt++;
    wen_prev = sram_write_enable;
    ren_prev = sram_read_enable;
  end

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  len;
    int          base;
    int          exp_done;
    bit          exp_err;
  } vec_t;

  int exp_dn = 0;

  task automatic run_burst(input vec_t v, input int stall_at, input int stall_len, input string tag);
    int          cyc, wbeat, stall_left, done_cyc;
    bit          got_done, err_seen;
    logic [15:0] a;
    logic        vld;
    if (!v.exp_err) begin
      for (int i = 0; i < int'(v.len); i++) begin
        a = v.addr + 16'(i * 16);
        if (v.wr) begin wa_q.push_back(a); wd_q.push_back(pat(v.base + i)); end
        else      begin ra_q.push_back(a); rd_q.push_back(pat(v.base + i)); end
      end
    end
    @(negedge clk);
    check({tag, "_req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_len = v.len;
    @(posedge clk);
    cyc = 0; wbeat = 0; stall_left = stall_len; got_done = 0; done_cyc = 0; err_seen = 0;
    while (!got_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      if (done) begin got_done = 1; done_cyc = cyc; err_seen = err; end
      vld = 1'b0;
      if (v.wr && wbeat < int'(v.len) && !got_done) begin
        if (wbeat == stall_at && stall_left > 0 && wdata_ready) begin
          stall_left--;
          check({tag, "_stall_wen"}, sram_write_enable, 0);
          check({tag, "_stall_addr"}, sram_address, 16'(v.addr + 16'(stall_at * 16)));
        end else begin
          vld = 1'b1;
        end
      end
      wdata_valid = vld;
      wdata = pat(v.base + wbeat);
      if (vld && wdata_ready) wbeat++;
    end
    wdata_valid = 1'b0;
    exp_dn++;
    if (!got_done) check({tag, "_timeout"}, 1, 0);
    else begin
      check({tag, "_done_cycle"}, done_cyc, v.exp_done);
      check({tag, "_err"}, err_seen, v.exp_err);
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_sb_empty"}, wa_q.size() + ra_q.size() + rd_q.size(), 0);
  endtask

  vec_t vt[6];
  int   dc;

  initial begin
    n_rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0;
    mem[16'hFFF0] = pat(16'h50);
    mem[16'h0000] = pat(16'h51);

    vt[0] = '{wr: 1, addr: 16'h0010, len: 8'd4, base: 16'hA,  exp_done: 16, exp_err: 0};
    vt[1] = '{wr: 0, addr: 16'h0010, len: 8'd4, base: 16'hA,  exp_done: 12, exp_err: 0};
    vt[2] = '{wr: 1, addr: 16'h0300, len: 8'd0, base: 0,      exp_done: 1,  exp_err: 0};
`ifdef SRAM_CTRL_BOUND_CHECK_EN
    vt[3] = '{wr: 0, addr: 16'hFFF0, len: 8'd2, base: 16'h50, exp_done: 1,  exp_err: 1};
`else
    vt[3] = '{wr: 0, addr: 16'hFFF0, len: 8'd2, base: 16'h50, exp_done: 6,  exp_err: 0};
`endif
    vt[4] = '{wr: 1, addr: 16'h1234, len: 8'd1, base: 16'h77, exp_done: 4,  exp_err: 0};
    vt[5] = '{wr: 0, addr: 16'h1234, len: 8'd1, base: 16'h77, exp_done: 3,  exp_err: 0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_ren", sram_read_enable, 0);
    check("rst_wen", sram_write_enable, 0);
    check("rst_rvld", rdata_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr", sram_address, 0);
    check("rst_rdata", rdata, 0);
    check("rst_wdata_ready", wdata_ready, 0);
    n_rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_burst(vt[i], -1, 0, $sformatf("vec%0d", i));
      if (!vt[i].wr && vt[i].len != 0 && !vt[i].exp_err)
        check($sformatf("vec%0d_rdata_hold", i), rdata, pat(vt[i].base + int'(vt[i].len) - 1));
    end

    // Write stall of 5 cycles before the second beat, then read back.
    run_burst('{wr: 1, addr: 16'h0200, len: 8'd3, base: 16'h30, exp_done: 17, exp_err: 0}, 1, 5, "stall");
    run_burst('{wr: 0, addr: 16'h0200, len: 8'd3, base: 16'h30, exp_done: 9, exp_err: 0}, -1, 0, "stall_rb");

    // Reset in the middle of a read access.
    ra_q.push_back(16'h0010);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010; req_len = 8'd4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("midrst_pre_ren", sram_read_enable, 1);
    dc = done_cnt;
    #2 n_rst = 1'b0;
    #1;
    check("midrst_ren", sram_read_enable, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", req_ready, 1);
    check("midrst_addr", sram_address, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    check("midrst_no_done", done_cnt, dc);
    check("midrst_sb", ra_q.size() + rd_q.size(), 0);
    run_burst('{wr: 0, addr: 16'h0040, len: 8'd0, base: 0, exp_done: 1, exp_err: 0}, -1, 0, "post_rst_len0");

    repeat (2) @(negedge clk);
    check("done_count", done_cnt, exp_dn);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
